clock_switch_request_ctrl: RTL and testbench
============================================

Name: clock_switch_request_ctrl

Overview:
- Sequencer that drives the two async_enable request lines of the glitch-free two-input clock output macro, and consumes the matching async_enable*_ack lines.
- Runs on an always-on reference clock and accepts source-select commands (off / source0 / source1) over a valid/ready interface.
- Enforces break-before-make: the old enable is dropped and its ack is seen low before the new enable is raised.
- Reports the active source and sets a sticky error flag on a handshake timeout.

Parameters:
- SYNC_STAGES, 2, flop depth of each ack synchronizer; legal values are 2 or more.
- TIMEOUT_CYCLES, 1024, number of cycles allowed for an ack to reach its expected level in one handshake phase.
- TIMEOUT_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter; derived, do not override.

Ports:
- clock  in  1  always-on reference clock.
- async_reset  in  1  asynchronous reset, active-high.
- select_valid  in  1  command valid.
- select_ready  out  1  high only in IDLE; a command transfers when select_valid and select_ready are both high.
- select_source  in  2  2'b00 = off, 2'b01 = source0, 2'b10 = source1, 2'b11 = illegal.
- async_enable0  out  1  registered level request for clock input 0.
- async_enable1  out  1  registered level request for clock input 1.
- async_enable0_ack  in  1  ack from the macro for input 0; asynchronous to clock.
- async_enable1_ack  in  1  ack from the macro for input 1; asynchronous to clock.
- active_source  out  2  source currently granted, same encoding as select_source.
- busy  out  1  high in any state other than IDLE.
- timeout_error  out  1  sticky; set on timeout.
- request_error  out  1  sticky; set when an illegal code is accepted.
- error_clear  in  1  clears both sticky errors and releases ERROR.

Behaviour:
- Reset values: async_enable0/1 = 0, active_source = 2'b00, busy = 0, select_ready = 1, both error flags = 0, state = IDLE, synchronizers = 0.
- Reset asserted mid-operation drops both enables immediately (asynchronous clear).
- Ack inputs pass through SYNC_STAGES-flop synchronizers; ack0_s and ack1_s denote the synchronized values. All decisions use only ack0_s and ack1_s.
- States: IDLE, DROP_OLD, RAISE_NEW, ERROR. select_ready = (state == IDLE).
- IDLE, accepted command, code == active_source: no-op. Stay in IDLE; outputs unchanged.
- IDLE, accepted code 2'b11: request_error is set; stay in IDLE.
- IDLE, accepted legal new code: latch it as target.
  - If active_source != 00: go to DROP_OLD. The current enable is cleared on that transition edge.
  - Otherwise go directly to RAISE_NEW.
- DROP_OLD: wait until the old source's ack_s == 0. Then set active_source = 00.
  - If target == 00: go to IDLE.
  - Otherwise: go to RAISE_NEW.
- RAISE_NEW: the target enable is set on entry. Wait until the target's ack_s == 1, then set active_source = target and go to IDLE.
- At most one enable is high at any time; this must hold in every state.
- Timeout counter:
  - Cleared on every entry to DROP_OLD or RAISE_NEW, and increments each cycle while in either state.
  - On reaching TIMEOUT_CYCLES-1 without the expected ack level: go to ERROR, clear both enables, set active_source = 00, set timeout_error.
- ERROR: select_ready = 0 and busy = 1. Exit to IDLE on a cycle where error_clear == 1 and ack0_s == 0 and ack1_s == 0.
- error_clear in IDLE clears the sticky flags. If an error sets in the same cycle as error_clear, the set wins.
- Ack level changes while in IDLE are ignored and do not alter state.
- Minimum latency: accept → enable asserted takes 1 cycle. Ack edge → state advance takes SYNC_STAGES+1 cycles.

Test Plan:
- Reset, then command 01 with the ack0 model returning 3 cycles after enable → async_enable0 = 1 one cycle after the transfer; active_source = 01 and busy = 0 SYNC_STAGES+1 cycles after ack0 rises; async_enable1 stays 0 throughout.
- From active 01, command 10 → async_enable0 falls; async_enable1 stays 0 until ack0_s == 0; then async_enable1 = 1; final active_source = 10; both enables never high in the same cycle.
- From active 10, command 00 → async_enable1 falls, active_source = 00 after ack1 drops, returns to IDLE with no enable high. Command 00 again → no-op with zero busy cycles.
- Ack model never responds, TIMEOUT_CYCLES = 16 → ERROR after 16 cycles in RAISE_NEW; timeout_error = 1, enables = 0, select_ready = 0. Pulse error_clear with acks low → IDLE, flag = 0.
- Command 11 → request_error = 1, no enable toggles, select_ready stays 1. Command 01 while busy → not accepted until select_ready = 1.
- Assert async_reset while in RAISE_NEW with async_enable1 = 1 → enable cleared in the same cycle without a clock edge; after release, state is IDLE and active_source = 00.

Source files
------------

// File: rtl/clock_switch_request_ctrl.sv
// Break-before-make sequencer for the two-input glitch-free clock macro.
// Drives enable requests and tracks synchronized acks with a phase timeout.
module clock_switch_request_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES+1)
) (
  input  logic       clock,
  input  logic       async_reset,
  input  logic       select_valid,
  output logic       select_ready,
  input  logic [1:0] select_source,
  output logic       async_enable0,
  output logic       async_enable1,
  input  logic       async_enable0_ack,
  input  logic       async_enable1_ack,
  output logic [1:0] active_source,
  output logic       busy,
  output logic       timeout_error,
  output logic       request_error,
  input  logic       error_clear
);

  typedef enum logic [1:0] {
    IDLE,
    DROP_OLD,
    RAISE_NEW,
    ERROR
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST =
    TIMEOUT_WIDTH'(TIMEOUT_CYCLES-1);

  state_t                   state_q, state_d;
  logic [1:0]               target_q, target_d;
  logic [1:0]               active_q, active_d;
  logic                     en0_q, en0_d;
  logic                     en1_q, en1_d;
  logic                     terr_q, terr_d;
  logic                     rerr_q, rerr_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0]   sync0_q, sync1_q;

  logic ack0_s, ack1_s;
  logic old_ack, tgt_ack, expired;

  assign ack0_s  = sync0_q[SYNC_STAGES-1];
  assign ack1_s  = sync1_q[SYNC_STAGES-1];
  assign old_ack = active_q[0] ? ack0_s : ack1_s;
  assign tgt_ack = target_q[0] ? ack0_s : ack1_s;
  assign expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    active_d = active_q;
    en0_d    = en0_q;
    en1_d    = en1_q;
    terr_d   = terr_q;
    rerr_d   = rerr_q;
    cnt_d    = cnt_q;
    if (error_clear && state_q == IDLE) begin
      terr_d = 1'b0;
      rerr_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (select_valid && select_source != active_q) begin
          if (select_source == 2'b11) begin
            rerr_d = 1'b1;
          end else begin
            target_d = select_source;
            cnt_d    = '0;
            // Old enable drops on the same edge that leaves IDLE
            if (active_q != 2'b00) begin
              state_d = DROP_OLD;
              en0_d   = 1'b0;
              en1_d   = 1'b0;
            end else begin
              state_d = RAISE_NEW;
              en0_d   = select_source[0];
              en1_d   = select_source[1];
            end
          end
        end
      end
      DROP_OLD: begin
        cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        if (!old_ack) begin
          active_d = 2'b00;
          if (target_q == 2'b00) begin
            state_d = IDLE;
          end else begin
            state_d = RAISE_NEW;
            cnt_d   = '0;
            en0_d   = target_q[0];
            en1_d   = target_q[1];
          end
        end else if (expired) begin
          state_d  = ERROR;
          en0_d    = 1'b0;
          en1_d    = 1'b0;
          active_d = 2'b00;
          terr_d   = 1'b1;
        end
      end
      RAISE_NEW: begin
        cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        if (tgt_ack) begin
          active_d = target_q;
          state_d  = IDLE;
        end else if (expired) begin
          state_d  = ERROR;
          en0_d    = 1'b0;
          en1_d    = 1'b0;
          active_d = 2'b00;
          terr_d   = 1'b1;
        end
      end
      ERROR: begin
        if (error_clear && !ack0_s && !ack1_s) begin
          state_d = IDLE;
          terr_d  = 1'b0;
          rerr_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      state_q  <= IDLE;
      target_q <= 2'b00;
      active_q <= 2'b00;
      en0_q    <= 1'b0;
      en1_q    <= 1'b0;
      terr_q   <= 1'b0;
      rerr_q   <= 1'b0;
      cnt_q    <= '0;
      sync0_q  <= '0;
      sync1_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      active_q <= active_d;
      en0_q    <= en0_d;
      en1_q    <= en1_d;
      terr_q   <= terr_d;
      rerr_q   <= rerr_d;
      cnt_q    <= cnt_d;
      sync0_q  <= {sync0_q[SYNC_STAGES-2:0], async_enable0_ack};
      sync1_q  <= {sync1_q[SYNC_STAGES-2:0], async_enable1_ack};
    end
  end

  assign select_ready  = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign async_enable0 = en0_q;
  assign async_enable1 = en1_q;
  assign active_source = active_q;
  assign timeout_error = terr_q;
  assign request_error = rerr_q;

endmodule

// File: tb/tb_clock_switch_request_ctrl.sv
// Directed bench for clock_switch_request_ctrl with a delayed-ack macro model.
module tb_clock_switch_request_ctrl;

  logic       clock = 1'b0;
  logic       async_reset = 1'b1;
  logic       select_valid = 1'b0;
  logic [1:0] select_source = 2'b00;
  logic       error_clear = 1'b0;
  logic       select_ready;
  logic       async_enable0, async_enable1;
  logic       async_enable0_ack, async_enable1_ack;
  logic [1:0] active_source;
  logic       busy, timeout_error, request_error;

  logic [15:0] h0 = '0;
  logic [15:0] h1 = '0;
  bit          ack_mute = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          overlap = 0;

  clock_switch_request_ctrl #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock            (clock),
    .async_reset      (async_reset),
    .select_valid     (select_valid),
    .select_ready     (select_ready),
    .select_source    (select_source),
    .async_enable0    (async_enable0),
    .async_enable1    (async_enable1),
    .async_enable0_ack(async_enable0_ack),
    .async_enable1_ack(async_enable1_ack),
    .active_source    (active_source),
    .busy             (busy),
    .timeout_error    (timeout_error),
    .request_error    (request_error),
    .error_clear      (error_clear)
  );

  always #5 clock = ~clock;

  // Macro model: ack follows its enable three cycles later
  always @(posedge clock) begin
    h0 <= {h0[14:0], async_enable0};
    h1 <= {h1[14:0], async_enable1};
  end
  assign async_enable0_ack = !ack_mute && h0[2];
  assign async_enable1_ack = !ack_mute && h1[2];

  always @(negedge clock)
    if (async_enable0 && async_enable1) overlap++;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] src);
    select_valid  = 1'b1;
    select_source = src;
    step();
    select_valid  = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (busy && n < 100);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({async_enable0, async_enable1, busy, select_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_ctrl got en0,en1,busy,rdy=%b want 0001",
               {async_enable0, async_enable1, busy, select_ready});
    end
    checks++;
    if ({active_source, timeout_error, request_error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state got act,terr,rerr=%b want 0000",
               {active_source, timeout_error, request_error});
    end
    async_reset = 1'b0;
    step();
  endtask

  task automatic test_raise();
    int n;
    send(2'b01);
    checks++;
    if ({async_enable0, async_enable1} !== 2'b10) begin
      errors++;
      $display("FAIL raise_en got %b want 10", {async_enable0, async_enable1});
    end
    wait_idle(n);
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL raise_latency got %0d want 6", n);
    end
    checks++;
    if (active_source !== 2'b01) begin
      errors++;
      $display("FAIL raise_active got %b want 01", active_source);
    end
  endtask

  task automatic test_switch();
    int n;
    send(2'b10);
    checks++;
    if ({async_enable0, async_enable1} !== 2'b00) begin
      errors++;
      $display("FAIL switch_drop got %b want 00", {async_enable0, async_enable1});
    end
    n = 0;
    do begin
      step();
      n++;
    end while (!async_enable1 && n < 100);
    checks++;
    if (n !== 6 || active_source !== 2'b00) begin
      errors++;
      $display("FAIL switch_make got n=%0d act=%b want 6 00", n, active_source);
    end
    wait_idle(n);
    checks++;
    if (n !== 6 || active_source !== 2'b10) begin
      errors++;
      $display("FAIL switch_done got n=%0d act=%b want 6 10", n, active_source);
    end
  endtask

  task automatic test_off();
    int n;
    send(2'b00);
    checks++;
    if (async_enable1 !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL off_drop got en1=%b busy=%b want 0 1", async_enable1, busy);
    end
    wait_idle(n);
    checks++;
    if (n !== 6 || active_source !== 2'b00 || async_enable0 || async_enable1) begin
      errors++;
      $display("FAIL off_done got n=%0d act=%b en=%b%b want 6 00 00",
               n, active_source, async_enable0, async_enable1);
    end
    send(2'b00);
    checks++;
    if (busy !== 1'b0 || select_ready !== 1'b1 || active_source !== 2'b00) begin
      errors++;
      $display("FAIL off_noop got busy=%b rdy=%b act=%b want 0 1 00",
               busy, select_ready, active_source);
    end
  endtask

  task automatic test_timeout();
    int n;
    ack_mute = 1'b1;
    send(2'b01);
    n = 0;
    do begin
      step();
      n++;
    end while (!timeout_error && n < 100);
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL timeout_cycles got %0d want 16", n);
    end
    checks++;
    if ({async_enable0, async_enable1, select_ready, busy, active_source} !== 6'b000100) begin
      errors++;
      $display("FAIL timeout_state got %b want 000100",
               {async_enable0, async_enable1, select_ready, busy, active_source});
    end
    step();
    checks++;
    if (select_ready !== 1'b0 || timeout_error !== 1'b1) begin
      errors++;
      $display("FAIL error_hold got rdy=%b terr=%b want 0 1", select_ready, timeout_error);
    end
    error_clear = 1'b1;
    step();
    error_clear = 1'b0;
    checks++;
    if (select_ready !== 1'b1 || timeout_error !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL error_clear got rdy=%b terr=%b busy=%b want 1 0 0",
               select_ready, timeout_error, busy);
    end
    repeat (4) step();
    ack_mute = 1'b0;
  endtask

  task automatic test_illegal();
    send(2'b11);
    checks++;
    if ({request_error, select_ready, busy, async_enable0, async_enable1} !== 5'b11000) begin
      errors++;
      $display("FAIL illegal_cmd got %b want 11000",
               {request_error, select_ready, busy, async_enable0, async_enable1});
    end
    error_clear = 1'b1;
    step();
    error_clear = 1'b0;
    checks++;
    if (request_error !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear got %b want 0", request_error);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit en0_seen;
    select_valid  = 1'b1;
    select_source = 2'b10;
    step();
    select_source = 2'b01;
    en0_seen = 1'b0;
    n = 0;
    do begin
      step();
      n++;
      if (async_enable0) en0_seen = 1'b1;
    end while (busy && n < 100);
    checks++;
    if (n !== 6 || en0_seen || active_source !== 2'b10) begin
      errors++;
      $display("FAIL hold_busy got n=%0d en0_seen=%b act=%b want 6 0 10",
               n, en0_seen, active_source);
    end
    step();
    select_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || async_enable1 !== 1'b0) begin
      errors++;
      $display("FAIL hold_accept got busy=%b en1=%b want 1 0", busy, async_enable1);
    end
    wait_idle(n);
    checks++;
    if (n !== 12 || active_source !== 2'b01) begin
      errors++;
      $display("FAIL hold_done got n=%0d act=%b want 12 01", n, active_source);
    end
  endtask

  task automatic test_async_reset();
    int n;
    send(2'b10);
    n = 0;
    do begin
      step();
      n++;
    end while (!async_enable1 && n < 100);
    checks++;
    if (async_enable1 !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre got en1=%b busy=%b want 1 1", async_enable1, busy);
    end
    #2;
    async_reset = 1'b1;
    #1;
    checks++;
    if ({async_enable0, async_enable1, active_source, select_ready} !== 5'b00001) begin
      errors++;
      $display("FAIL areset_now got %b want 00001",
               {async_enable0, async_enable1, active_source, select_ready});
    end
    @(negedge clock);
    async_reset = 1'b0;
    step();
    step();
    checks++;
    if ({busy, active_source, async_enable0, async_enable1} !== 5'b00000) begin
      errors++;
      $display("FAIL areset_after got %b want 00000",
               {busy, active_source, async_enable0, async_enable1});
    end
  endtask

  initial begin
    test_reset();
    test_raise();
    test_switch();
    test_off();
    test_timeout();
    test_illegal();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL enable_overlap got %0d cycles want 0", overlap);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
